// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the boot-time instruction loader.
// Holds the loader state encoding, the bytes-per-word constant and the
// instruction address step (matches the datapath's PC+4 increment).
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LOAD   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

  // Byte address of instruction word idx.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx * ADDR_STEP;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream valid/ready handshake into the loader.
//   valid : source has a byte on data
//   data  : stream byte
//   ready : loader accepts a byte this cycle
// master = byte source, slave = loader.
interface prog_loader_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/prog_loader_byte_packer.sv
// prog_loader_byte_packer: assembles big-endian 32-bit words from bytes.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_shift      : accept i_byte this cycle
//   i_byte       : incoming byte
//   o_word       : assembled word (first byte of a word ends up in [31:24])
//   o_word_full  : the next shifted byte completes the current word
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= {r_word[23:0], i_byte};
      // 2-bit counter wraps 3 -> 0 on the word-completing byte
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  assign o_word      = r_word;
  assign o_word_full = (r_cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader feeding the instruction memory.
// Receives a 2-byte big-endian length header followed by LEN big-endian
// instruction words, writes them to consecutive word addresses and then
// releases the datapath with o_cpu_run.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   s_in              : byte stream (valid/ready)
//   o_im_we           : instruction-memory write strobe (one cycle)
//   o_im_addr         : byte address of the write
//   o_im_wdata        : instruction word being written
//   o_cpu_run         : program fully loaded
//   o_load_err        : header length exceeded MAX_WORDS
//   o_words_loaded    : number of words written so far
//
// state  | meaning
// LEN_HI | waiting for length MSB
// LEN_LO | waiting for length LSB, then range check
// LOAD   | collecting the 4 bytes of the current word
// WRITE  | one-cycle instruction-memory write
// DONE   | program loaded, datapath released
// ERR    | header too long, loader halted
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int LEN_W     = 16   // header is 16 bits wide, so LEN_W >= 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  prog_loader_if.slave     s_in,
  output logic             o_im_we,
  output logic [31:0]      o_im_addr,
  output logic [31:0]      o_im_wdata,
  output logic             o_cpu_run,
  output logic             o_load_err,
  output logic [LEN_W-1:0] o_words_loaded
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_len_hi;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_word_cnt;
  logic [LEN_W-1:0] w_cnt_inc;
  logic [15:0]      w_len;
  logic             w_in_ready;
  logic             w_xfer;
  logic             w_word_full;
  logic [31:0]      w_word;

  // Ready depends only on state (and reset), never on valid.
  assign w_in_ready = ~i_rst & ((r_state == ST_LEN_HI) |
                                (r_state == ST_LEN_LO) |
                                (r_state == ST_LOAD));
  assign w_xfer     = s_in.valid & w_in_ready;
  assign w_len      = {r_len_hi, s_in.data};
  assign w_cnt_inc  = r_word_cnt + LEN_W'(1);

  prog_loader_byte_packer u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_shift     (w_xfer & (r_state == ST_LOAD)),
    .i_byte      (s_in.data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_LEN_HI;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LEN_HI: if (w_xfer) w_state_nxt = ST_LEN_LO;
      ST_LEN_LO: begin
        if (w_xfer) begin
          if (w_len == 16'd0)                 w_state_nxt = ST_DONE;
          else if (w_len > 16'(MAX_WORDS))    w_state_nxt = ST_ERR;
          else                                w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:  if (w_xfer && w_word_full) w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = (w_cnt_inc == r_len) ? ST_DONE : ST_LOAD;
      ST_DONE:  w_state_nxt = ST_DONE;
      ST_ERR:   w_state_nxt = ST_ERR;
      default:  w_state_nxt = ST_LEN_HI;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len_hi   <= '0;
      r_len      <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_xfer && r_state == ST_LEN_HI) r_len_hi <= s_in.data;
      if (w_xfer && r_state == ST_LEN_LO) r_len <= LEN_W'(w_len);
      if (r_state == ST_WRITE)            r_word_cnt <= w_cnt_inc;
    end
  end

  // Reset suppresses a write that would otherwise be in flight this cycle.
  assign o_im_we        = (r_state == ST_WRITE) & ~i_rst;
  assign o_im_addr      = o_im_we ? word_addr(32'(r_word_cnt)) : 32'd0;
  assign o_im_wdata     = o_im_we ? w_word : 32'd0;
  assign o_cpu_run      = (r_state == ST_DONE);
  assign o_load_err     = (r_state == ST_ERR);
  assign o_words_loaded = r_word_cnt;
  assign s_in.ready     = w_in_ready;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_run;
  logic        load_err;
  logic [15:0] words_loaded;

  prog_loader_if u_if ();

  prog_loader #(.MAX_WORDS(256), .LEN_W(16)) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .s_in           (u_if.slave),
    .o_im_we        (im_we),
    .o_im_addr      (im_addr),
    .o_im_wdata     (im_wdata),
    .o_cpu_run      (cpu_run),
    .o_load_err     (load_err),
    .o_words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_xfer = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every im_we pulse and every cpu_run rising edge.
  logic [31:0] we_addr_q[$];
  logic [31:0] we_data_q[$];
  logic [31:0] we_cyc_q[$];
  int          run_rise_cyc = -1;
  logic        run_prev = 1'b0;

  always @(negedge clk) begin
    if (im_we) begin
      we_addr_q.push_back(im_addr);
      we_data_q.push_back(im_wdata);
      we_cyc_q.push_back(32'(cyc));
    end
    if (cpu_run && !run_prev) run_rise_cyc <= cyc;
    run_prev <= cpu_run;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    u_if.valid = 1'b1;
    u_if.data  = b;
    while (!u_if.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("send_timeout", 32'(n), 32'd0);
      u_if.valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 last_xfer = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      u_if.valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    u_if.valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    int t0;
    int t1;
    logic [7:0] tog_bytes[4];
    tog_bytes[0] = 8'hDE; tog_bytes[1] = 8'hAD; tog_bytes[2] = 8'hBE; tog_bytes[3] = 8'hEF;
    u_if.valid = 1'b0;
    u_if.data  = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(u_if.ready), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", im_addr, 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_state", 32'(u_dut.r_state), 32'(ST_LEN_HI));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", 32'(u_if.ready), 32'd1);

    // Two-word program, back-to-back bytes
    base = we_addr_q.size();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    t0 = last_xfer;
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    t1 = last_xfer;
    idle(4);
    chk("w2_count", 32'(we_addr_q.size() - base), 32'd2);
    chk("w2_addr0", q_at(we_addr_q, base), 32'h0000_0000);
    chk("w2_data0", q_at(we_data_q, base), 32'h1122_3344);
    chk("w2_lat0", q_at(we_cyc_q, base), 32'(t0));
    chk("w2_addr1", q_at(we_addr_q, base + 1), 32'h0000_0004);
    chk("w2_data1", q_at(we_data_q, base + 1), 32'hAABB_CCDD);
    chk("w2_lat1", q_at(we_cyc_q, base + 1), 32'(t1));
    chk("w2_run_lat", 32'(run_rise_cyc), q_at(we_cyc_q, base + 1) + 32'd1);
    chk("w2_words", 32'(words_loaded), 32'd2);
    chk("w2_cpu_run", 32'(cpu_run), 32'd1);

    // Extra bytes after DONE are never taken
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      u_if.valid = 1'b1;
      u_if.data  = 8'h5A;
      #1;
      chk("done_ready", 32'(u_if.ready), 32'd0);
      chk("done_run", 32'(cpu_run), 32'd1);
    end
    idle(1);
    chk("done_no_we", 32'(we_addr_q.size() - base), 32'd2);
    chk("done_words", 32'(words_loaded), 32'd2);

    // Empty program
    do_reset();
    base = we_addr_q.size();
    send_byte(8'h00); send_byte(8'h00);
    t0 = last_xfer;
    idle(3);
    chk("z_no_we", 32'(we_addr_q.size() - base), 32'd0);
    chk("z_run_lat", 32'(run_rise_cyc), 32'(t0));
    chk("z_cpu_run", 32'(cpu_run), 32'd1);
    chk("z_ready", 32'(u_if.ready), 32'd0);

    // LEN == MAX_WORDS is accepted
    do_reset();
    send_byte(8'h01); send_byte(8'h00);
    idle(1);
    chk("max_state", 32'(u_dut.r_state), 32'(ST_LOAD));
    chk("max_err", 32'(load_err), 32'd0);
    chk("max_ready", 32'(u_if.ready), 32'd1);

    // LEN == MAX_WORDS+1 is rejected
    do_reset();
    base = we_addr_q.size();
    send_byte(8'h01); send_byte(8'h01);
    idle(1);
    chk("err_flag", 32'(load_err), 32'd1);
    chk("err_run", 32'(cpu_run), 32'd0);
    chk("err_ready", 32'(u_if.ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      u_if.valid = 1'b1;
      u_if.data  = 8'h77;
      #1 chk("err_hold_ready", 32'(u_if.ready), 32'd0);
    end
    idle(2);
    chk("err_no_we", 32'(we_addr_q.size() - base), 32'd0);
    chk("err_flag_held", 32'(load_err), 32'd1);

    // One word with in_valid toggling
    do_reset();
    base = we_addr_q.size();
    send_byte(8'h00); idle(1); send_byte(8'h01); idle(1);
    for (int i = 0; i < 4; i++) begin
      send_byte(tog_bytes[i]);
      idle(1);
    end
    idle(3);
    chk("tog_count", 32'(we_addr_q.size() - base), 32'd1);
    chk("tog_addr", q_at(we_addr_q, base), 32'h0000_0000);
    chk("tog_data", q_at(we_data_q, base), 32'hDEAD_BEEF);
    chk("tog_words", 32'(words_loaded), 32'd1);
    chk("tog_run", 32'(cpu_run), 32'd1);

    // Reset in the middle of a word
    do_reset();
    base = we_addr_q.size();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk);
    rst = 1'b1;
    u_if.valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_state", 32'(u_dut.r_state), 32'(ST_LEN_HI));
    chk("mid_we", 32'(im_we), 32'd0);
    chk("mid_words", 32'(words_loaded), 32'd0);
    chk("mid_assembly", u_dut.u_packer.r_word, 32'd0);
    chk("mid_run", 32'(cpu_run), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    idle(3);
    chk("mid_count", 32'(we_addr_q.size() - base), 32'd1);
    chk("mid_addr", q_at(we_addr_q, base), 32'h0000_0000);
    chk("mid_data", q_at(we_data_q, base), 32'h1234_5678);
    chk("mid_run_after", 32'(cpu_run), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
